// File: rtl/ndro_bank.sv
// Bank of WIDTH non-destructive readout cells sharing one readout strobe, with
// per-lane setup/hold checking against the strobe and a saturating violation counter.
module ndro_bank #(
    parameter int WIDTH       = 8,
    parameter int SETUP_CYC   = 1,
    parameter int HOLD_CYC    = 2,
    parameter int DESTRUCTIVE = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] set_i,
    input  logic [WIDTH-1:0] clr_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] state_q,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] viol_setup,
    output logic [WIDTH-1:0] viol_hold,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam int SAT = ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) + 1;
    localparam int AW  = $clog2(SAT + 1);
    localparam logic [AW-1:0] SAT_V   = AW'(SAT);
    localparam logic [AW-1:0] SETUP_V = AW'(SETUP_CYC);
    localparam logic [AW-1:0] HOLD_V  = AW'(HOLD_CYC);

    // age_q[i]: cycles since the last set/clr event on lane i (never below 1).
    // since_rd_q: cycles since the last rd_i. Both saturate at SAT.
    logic [AW-1:0]    age_q [WIDTH];
    logic [AW-1:0]    since_rd_q;

    logic [WIDTH-1:0] event_v;
    logic [WIDTH-1:0] conflict_d;
    logic [WIDTH-1:0] setup_d;
    logic [WIDTH-1:0] hold_d;
    logic [WIDTH-1:0] state_d;
    logic             any_viol;

    always_comb begin
        event_v    = set_i | clr_i;
        conflict_d = set_i & clr_i;
        setup_d    = '0;
        hold_d     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // Ages start at 1, so SETUP_CYC=0 can never match here.
            if (rd_i && (age_q[i] <= SETUP_V)) begin
                setup_d[i] = 1'b1;
            end
            // An event in the same cycle as rd_i is distance 0 and always violates.
            if (event_v[i] && (rd_i || (since_rd_q < HOLD_V))) begin
                hold_d[i] = 1'b1;
            end
        end
        state_d = (state_q | (set_i & ~clr_i)) & ~(clr_i & ~set_i);
        if ((DESTRUCTIVE != 0) && rd_i) begin
            state_d = set_i;
        end
        any_viol = |(setup_d | hold_d | conflict_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            viol_setup <= '0;
            viol_hold  <= '0;
            conflict   <= '0;
            viol_cnt   <= '0;
            since_rd_q <= SAT_V;
            for (int i = 0; i < WIDTH; i++) begin
                age_q[i] <= SAT_V;
            end
        end else begin
            state_q    <= state_d;
            rd_valid   <= rd_i;
            rd_data    <= rd_i ? state_q : '0;
            viol_setup <= setup_d;
            viol_hold  <= hold_d;
            conflict   <= conflict_d;
            if (any_viol && (viol_cnt != {CNT_W{1'b1}})) begin
                viol_cnt <= viol_cnt + CNT_W'(1);
            end
            if (rd_i) begin
                since_rd_q <= AW'(1);
            end else if (since_rd_q != SAT_V) begin
                since_rd_q <= since_rd_q + AW'(1);
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (event_v[i]) begin
                    age_q[i] <= AW'(1);
                end else if (age_q[i] != SAT_V) begin
                    age_q[i] <= age_q[i] + AW'(1);
                end
            end
        end
    end

endmodule
